lpc_host_ctrl: RTL and testbench

//  Parametrised LPC host master; successor to the single-mode memory-only LPC engine. Runs one
//  LPC transaction per request: IO or memory, read or write, with full SYNC decoding (ready,

---
 rtl/lpc_host_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_lpc_host_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_host_ctrl.sv
// LPC host master: one IO/memory read/write transaction per request, with SYNC decoding,
// bounded wait timeouts and the LFRAME# abort sequence.
module lpc_host_ctrl #(
    parameter int unsigned SHORT_WAIT_MAX = 8,
    parameter int unsigned LONG_WAIT_MAX  = 1024,
    parameter int unsigned NOSYNC_MAX     = 3
) (
    input  logic        lclk_i,
    input  logic        lreset_i,
    input  logic [3:0]  lad_in_i,
    output logic [3:0]  lad_out_o,
    output logic        lad_oe_o,
    output logic        lframe_o,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_io_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    output logic [1:0]  rsp_status_o
);

    localparam int unsigned WCNT_W = $clog2(LONG_WAIT_MAX + 1);
    localparam int unsigned NS_W   = $clog2(NOSYNC_MAX + 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_START     = 4'd1;
    localparam logic [3:0] S_CYCDIR    = 4'd2;
    localparam logic [3:0] S_ADDR      = 4'd3;
    localparam logic [3:0] S_WDATA     = 4'd4;
    localparam logic [3:0] S_TAR_H     = 4'd5;
    localparam logic [3:0] S_TAR_Z     = 4'd6;
    localparam logic [3:0] S_SYNC      = 4'd7;
    localparam logic [3:0] S_RDATA     = 4'd8;
    localparam logic [3:0] S_TAR2      = 4'd9;
    localparam logic [3:0] S_ABORT     = 4'd10;
    localparam logic [3:0] S_ABORT_END = 4'd11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_NORESP  = 2'b11;

    logic [3:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              io_q, io_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              long_q, long_d;
    logic [NS_W-1:0]   nosync_cnt_q, nosync_cnt_d;
    logic [1:0]        status_q, status_d;
    logic [3:0]        rdata_lo_q, rdata_lo_d;

    logic [3:0]        lad_out_q, lad_out_d;
    logic              lad_oe_q, lad_oe_d;
    logic              lframe_q, lframe_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_status_q, rsp_status_d;

    logic              long_now;
    logic [WCNT_W-1:0] wait_lim;
    logic [2:0]        nib_sel;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        io_d         = io_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        long_d       = long_q;
        nosync_cnt_d = nosync_cnt_q;
        status_d     = status_q;
        rdata_lo_d   = rdata_lo_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;
        lad_out_d    = 4'hF;
        lad_oe_d     = 1'b0;
        lframe_d     = 1'b1;
        nib_sel      = 3'd0;

        // A 0110 on the current cycle already selects the long limit.
        long_now = long_q | (lad_in_i == 4'b0110);
        wait_lim = long_now ? WCNT_W'(LONG_WAIT_MAX) : WCNT_W'(SHORT_WAIT_MAX);

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    io_d    = req_io_i;
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_CYCDIR;
                cnt_d   = 3'd0;
            end
            S_CYCDIR: begin
                state_d = S_ADDR;
                cnt_d   = 3'd0;
            end
            S_ADDR: begin
                if (cnt_q == (io_q ? 3'd3 : 3'd7)) begin
                    state_d = write_q ? S_WDATA : S_TAR_H;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WDATA: begin
                if (cnt_q == 3'd1) begin
                    state_d = S_TAR_H;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_TAR_H: state_d = S_TAR_Z;
            S_TAR_Z: begin
                state_d      = S_SYNC;
                wait_cnt_d   = '0;
                long_d       = 1'b0;
                nosync_cnt_d = '0;
            end
            S_SYNC: begin
                nosync_cnt_d = '0;
                cnt_d        = 3'd0;
                case (lad_in_i)
                    4'b0000, 4'b1001: begin
                        status_d = ST_OK;
                        state_d  = write_q ? S_TAR2 : S_RDATA;
                    end
                    4'b1010: begin
                        status_d = ST_ERR;
                        state_d  = write_q ? S_TAR2 : S_RDATA;
                    end
                    4'b0101, 4'b0110: begin
                        long_d = long_now;
                        if (wait_cnt_q == wait_lim) begin
                            status_d = ST_TIMEOUT;
                            state_d  = S_ABORT;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                        end
                    end
                    4'b1111: begin
                        if (nosync_cnt_q == NS_W'(NOSYNC_MAX - 1)) begin
                            status_d = ST_NORESP;
                            state_d  = S_ABORT;
                        end else begin
                            nosync_cnt_d = nosync_cnt_q + NS_W'(1);
                        end
                    end
                    default: begin
                        status_d = ST_NORESP;
                        state_d  = S_ABORT;
                    end
                endcase
            end
            S_RDATA: begin
                if (cnt_q == 3'd0) begin
                    rdata_lo_d = lad_in_i;
                    cnt_d      = 3'd1;
                end else begin
                    rsp_rdata_d = {lad_in_i, rdata_lo_q};
                    state_d     = S_TAR2;
                    cnt_d       = 3'd0;
                end
            end
            S_TAR2: begin
                if (cnt_q == 3'd1) begin
                    state_d      = S_IDLE;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = status_q;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_ABORT: begin
                if (cnt_q == 3'd3) begin
                    state_d = S_ABORT_END;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_ABORT_END: begin
                state_d      = S_IDLE;
                rsp_valid_d  = 1'b1;
                rsp_status_d = status_q;
            end
            default: state_d = S_IDLE;
        endcase

        // Pad outputs are decoded from the next state so they register in step with it.
        case (state_d)
            S_START: begin
                lframe_d  = 1'b0;
                lad_oe_d  = 1'b1;
                lad_out_d = 4'b0000;
            end
            S_CYCDIR: begin
                lad_oe_d  = 1'b1;
                lad_out_d = {1'b0, ~io_d, write_d, 1'b0};
            end
            S_ADDR: begin
                lad_oe_d  = 1'b1;
                nib_sel   = (io_d ? 3'd3 : 3'd7) - cnt_d;
                lad_out_d = addr_d[{nib_sel, 2'b00} +: 4];
            end
            S_WDATA: begin
                lad_oe_d  = 1'b1;
                lad_out_d = cnt_d[0] ? wdata_d[7:4] : wdata_d[3:0];
            end
            S_TAR_H, S_ABORT_END: lad_oe_d = 1'b1;
            S_ABORT: begin
                lframe_d = 1'b0;
                lad_oe_d = 1'b1;
            end
            default: ;
        endcase

        req_ready_d = (state_d == S_IDLE) && !rsp_valid_d;
    end

    always_ff @(posedge lclk_i or negedge lreset_i) begin
        if (!lreset_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            io_q         <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 8'd0;
            wait_cnt_q   <= '0;
            long_q       <= 1'b0;
            nosync_cnt_q <= '0;
            status_q     <= ST_OK;
            rdata_lo_q   <= 4'd0;
            lad_out_q    <= 4'hF;
            lad_oe_q     <= 1'b0;
            lframe_q     <= 1'b1;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 8'd0;
            rsp_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            io_q         <= io_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            long_q       <= long_d;
            nosync_cnt_q <= nosync_cnt_d;
            status_q     <= status_d;
            rdata_lo_q   <= rdata_lo_d;
            lad_out_q    <= lad_out_d;
            lad_oe_q     <= lad_oe_d;
            lframe_q     <= lframe_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign lad_out_o    = lad_out_q;
    assign lad_oe_o     = lad_oe_q;
    assign lframe_o     = lframe_q;
    assign req_ready_o  = req_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_status_o = rsp_status_q;

endmodule

// File: tb/tb_lpc_host_ctrl.sv
// Scoreboard bench for lpc_host_ctrl: expected responses and host-driven LAD nibbles are queued
// by the stimulus and popped by independent monitors.
module tb_lpc_host_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  lad_in = 4'hF;
    logic [3:0]  lad_out;
    logic        lad_oe;
    logic        lframe;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_io = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [7:0]  req_wdata = 8'd0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_status;

    typedef struct {
        logic [7:0] rdata;
        logic [1:0] status;
        int         acc;
        int         lat;
    } rsp_t;

    rsp_t       rsp_q[$];
    logic [4:0] bus_q[$];
    logic [3:0] scr_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    int         bus_idx = 0;
    bit         bus_en = 1'b0;

    lpc_host_ctrl #(
        .SHORT_WAIT_MAX(8),
        .LONG_WAIT_MAX (16),
        .NOSYNC_MAX    (3)
    ) dut (
        .lclk_i      (clk),
        .lreset_i    (rst_n),
        .lad_in_i    (lad_in),
        .lad_out_o   (lad_out),
        .lad_oe_o    (lad_oe),
        .lframe_o    (lframe),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_io_i    (req_io),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_status_o(rsp_status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Response monitor
    always @(negedge clk) begin : rsp_mon
        rsp_t e;
        if (rst_n && rsp_valid) begin
            if (rsp_q.size() == 0) begin
                n_total++;
                $display("FAIL rsp_unexpected: rsp_valid with empty scoreboard at cycle %0d", cyc);
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_status", 32'(rsp_status), 32'(e.status));
                chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                chk("ready_low_during_rsp", 32'(req_ready), 32'd0);
            end
        end
    end

    // Host-driven LAD monitor
    always @(negedge clk) begin : bus_mon
        logic [4:0] e;
        if (bus_en && rst_n && lad_oe) begin
            if (bus_q.size() == 0) begin
                n_total++;
                $display("FAIL bus_unexpected: host drove {lframe,lad}=0x%0h, expected nothing", {lframe, lad_out});
            end else begin
                e = bus_q.pop_front();
                chk($sformatf("bus[%0d]", bus_idx), 32'({lframe, lad_out}), 32'(e));
                bus_idx++;
            end
        end
    end

    task automatic push_hdr(input bit io, input bit wr, input logic [31:0] addr, input logic [7:0] wd);
        logic [4:0] n;
        bus_q.push_back({1'b0, 4'h0});
        bus_q.push_back({1'b1, 1'b0, ~io, wr, 1'b0});
        for (int i = (io ? 3 : 7); i >= 0; i--) begin
            n = {1'b1, addr[i*4 +: 4]};
            bus_q.push_back(n);
        end
        if (wr) begin
            bus_q.push_back({1'b1, wd[3:0]});
            bus_q.push_back({1'b1, wd[7:4]});
        end
        bus_q.push_back({1'b1, 4'hF});
    endtask

    task automatic push_abort();
        for (int i = 0; i < 4; i++) bus_q.push_back({1'b0, 4'hF});
        bus_q.push_back({1'b1, 4'hF});
    endtask

    task automatic add_scr(input logic [3:0] nib, input int times);
        for (int i = 0; i < times; i++) scr_q.push_back(nib);
    endtask

    task automatic run_txn(input bit io, input bit wr, input logic [31:0] addr, input logic [7:0] wd,
                           input logic [7:0] exp_rd, input logic [1:0] exp_st, input int exp_lat,
                           input bit abort);
        rsp_t e;
        int   k;
        push_hdr(io, wr, addr, wd);
        if (abort) push_abort();
        @(posedge clk); #1;
        req_io = io; req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (k == 20) begin
            n_total++;
            $display("FAIL accept_timeout: req_ready stayed 0 for 20 cycles");
            req_valid = 1'b0;
            scr_q.delete();
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Scramble request inputs to show the DUT uses its latched copy.
        req_io = ~io; req_write = ~wr; req_addr = ~addr; req_wdata = ~wd;
        e.rdata = exp_rd; e.status = exp_st; e.acc = cyc; e.lat = exp_lat;
        rsp_q.push_back(e);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!lad_oe) break;
        end
        if (k == 40) begin
            n_total++;
            $display("FAIL turnaround_timeout: host never released LAD");
        end
        foreach (scr_q[i]) begin
            @(posedge clk); #1;
            lad_in = scr_q[i];
        end
        @(posedge clk); #1;
        lad_in = 4'hF;
        scr_q.delete();
        for (k = 0; k < 100; k++) begin
            if (rsp_q.size() == 0) break;
            @(negedge clk);
        end
        if (k == 100) begin
            n_total++;
            $display("FAIL rsp_timeout: no response within 100 cycles");
            rsp_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lframe", 32'(lframe), 32'd1);
        chk("rst_oe", 32'(lad_oe), 32'd0);
        chk("rst_lad_out", 32'(lad_out), 32'hF);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        bus_en = 1'b1;

        // IO write, immediate ready
        add_scr(4'h0, 1);
        run_txn(1'b1, 1'b1, 32'h0000_0080, 8'h5A, 8'h00, 2'b00, 13, 1'b0);
        // Mem read, two short waits
        add_scr(4'h5, 2); add_scr(4'h0, 1); add_scr(4'hA, 1); add_scr(4'h5, 1);
        run_txn(1'b0, 1'b0, 32'hFFFF_FFF0, 8'h00, 8'h5A, 2'b00, 19, 1'b0);
        // IO read, no device
        add_scr(4'hF, 3);
        run_txn(1'b1, 1'b0, 32'h0000_1234, 8'h00, 8'h5A, 2'b11, 16, 1'b1);
        // Mem read, long wait exceeds limit of 16
        add_scr(4'h6, 17);
        run_txn(1'b0, 1'b0, 32'h0000_0010, 8'h00, 8'h5A, 2'b10, 34, 1'b1);
        // Mem read, 15 long waits then ready
        add_scr(4'h6, 15); add_scr(4'h0, 1); add_scr(4'h7, 1); add_scr(4'hE, 1);
        run_txn(1'b0, 1'b0, 32'h0000_0020, 8'h00, 8'hE7, 2'b00, 32, 1'b0);
        // Mem read, SYNC error with data
        add_scr(4'hA, 1); add_scr(4'h3, 1); add_scr(4'hC, 1);
        run_txn(1'b0, 1'b0, 32'h8765_4321, 8'h00, 8'hC3, 2'b01, 17, 1'b0);
        // Mem write, SYNC error
        add_scr(4'hA, 1);
        run_txn(1'b0, 1'b1, 32'h0000_0004, 8'h96, 8'hC3, 2'b01, 17, 1'b0);
        // IO read, short wait exceeds limit of 8
        add_scr(4'h5, 9);
        run_txn(1'b1, 1'b0, 32'h0000_0060, 8'h00, 8'hC3, 2'b10, 22, 1'b1);
        // IO read, 1001 ready
        add_scr(4'h9, 1); add_scr(4'h1, 1); add_scr(4'h2, 1);
        run_txn(1'b1, 1'b0, 32'h0000_ABCD, 8'h00, 8'h21, 2'b00, 13, 1'b0);
        // IO write, illegal SYNC nibble
        add_scr(4'h3, 1);
        run_txn(1'b1, 1'b1, 32'h0000_0070, 8'hF0, 8'h21, 2'b11, 16, 1'b1);
        // IO read, no-sync run broken by a wait nibble
        add_scr(4'hF, 2); add_scr(4'h5, 1); add_scr(4'hF, 2); add_scr(4'h0, 1);
        add_scr(4'h4, 1); add_scr(4'hB, 1);
        run_txn(1'b1, 1'b0, 32'h0000_0064, 8'h00, 8'hB4, 2'b00, 18, 1'b0);

        // Reset in the middle of the address phase
        bus_en = 1'b0;
        @(posedge clk); #1;
        req_io = 1'b1; req_write = 1'b0; req_addr = 32'h0000_55AA; req_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_lframe", 32'(lframe), 32'd1);
        chk("midrst_oe", 32'(lad_oe), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("midrst_rsp_status", 32'(rsp_status), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_first_edge", 32'(req_ready), 32'd1);
        bus_q.delete();
        bus_en = 1'b1;

        // Recovery after reset
        add_scr(4'h0, 1); add_scr(4'h7, 2);
        run_txn(1'b1, 1'b0, 32'h0000_0002, 8'h00, 8'h77, 2'b00, 13, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
